fcmp_unit: RTL and testbench
============================

FCMP_UNIT -- requirements
Module: fcmp_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port a, input, 32 bits: IEEE-754 single operand A.
REQ-004 SHALL have ports a_valid (input, 1) and a_ready (output, 1): A channel handshake.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single operand B.
REQ-006 SHALL have ports b_valid (input, 1) and b_ready (output, 1): B channel handshake.
REQ-007 SHALL have port op, input, 3 bits: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; 6-7 reserved.
REQ-008 SHALL have ports op_valid (input, 1) and op_ready (output, 1): op channel handshake.
REQ-009 SHALL have port result, output, 8 bits: bit0 = A op B true; bits 7:1 always 0.
REQ-010 SHALL have ports result_valid (output, 1) and result_ready (input, 1): result handshake; initiators without backpressure tie result_ready to 1.

Function
REQ-011 SHALL transfer on a channel only in a cycle where valid and ready are both 1.
REQ-012 SHALL give each input channel a one-entry holding register with a full flag; the flag sets on transfer and clears on fire.
REQ-013 SHALL define fire = a_full & b_full & op_full & (!result_valid | result_ready).
REQ-014 SHALL drive x_ready = !x_full | fire for each channel x; a new operand is accepted in the same cycle as fire.
REQ-015 SHALL accept channels independently and in any order or cycle spacing; an operation fires only once all three are held.
REQ-016 SHALL on fire load result and set result_valid at the next edge: latency is 2 edges from the final operand transfer to result_valid high.
REQ-017 SHALL clear result_valid on a result transfer with no same-cycle fire.
REQ-018 SHALL keep result and result_valid stable while result_valid & !result_ready; held operands remain stored and readies stay low.
REQ-019 SHALL sustain one result per cycle when all channels are valid each cycle and result_ready=1.
REQ-020 SHALL order values by mapping sign-magnitude to a monotonic key: positive gives {1,bits[30:0]}; negative gives ~bits.
REQ-021 SHALL treat +0 (0x00000000) and -0 (0x80000000) as equal for every op.
REQ-022 SHALL produce result 0x00 for reserved op codes 6-7.
REQ-023 SHALL produce results in operation-arrival order; no reordering or dropping.

Reset
REQ-024 SHALL on rstn low immediately clear all full flags, result_valid=0, and result=0x00; a_ready, b_ready and op_ready read 1 once rstn is high.
REQ-025 SHALL discard captured operands and any pending result when reset is asserted mid-operation; no result appears after release.

Configuration
REQ-026 SHALL honour macro FCMP_NAN_CHECK_EN.
- Defined: an operand with exponent 0xFF and nonzero mantissa is NaN; any NaN gives result bit0=0 for EQ/LT/LE/GT/GE and 1 for NE.
- Undefined: no NaN detection; NaNs are ordered by the REQ-020 key like any other value.

Verification
REQ-027 a=0x3F800000, b=0x40000000, op=2 in the same cycle, result_ready=1 -> result=0x01, result_valid high 2 edges later for 1 cycle.
REQ-028 a=0x00000000, b=0x80000000, op=0 -> result=0x01; the same operands with op=2 -> 0x00.
REQ-029 a sent at cycle 0, op at cycle 3, b (0xC0000000) at cycle 5, a=0x3F800000, op=4 -> a_ready low cycles 1-5, result=0x01 valid at cycle 7.
REQ-030 result_ready=0 with two operation sets offered back-to-back -> first result held stable, second set captured and readies low; result_ready=1 -> both results delivered in order on consecutive cycles.
REQ-031 a=0x7FC00000, b=0x3F800000: with FCMP_NAN_CHECK_EN, op=0 gives 0x00 and op=1 gives 0x01; without the macro, op=4 gives 0x01.
REQ-032 a captured, rstn pulsed low for 1 cycle, then b and op sent -> no result_valid; a_ready=1 after release.

Source files
------------

// File: rtl/fcmp_unit.sv
// ============================================================================
// Module      : fcmp_unit
// Description : IEEE-754 single-precision comparator. Operands A and B and
//               the op code arrive on three independent valid/ready channels,
//               each with a one-entry holding register. The comparison fires
//               once all three are held, and the 8-bit result (bit0 = A op B)
//               is returned on a valid/ready result channel.
// Config      : FCMP_NAN_CHECK_EN - when defined, a NaN on either operand
//               forces EQ/LT/LE/GT/GE false and NE true.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcmp_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] a,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] b,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  op,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [7:0]  result,
  output logic        result_valid,
  input  logic        result_ready
);

  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_LE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        a_full_q, a_full_d;
  logic        b_full_q, b_full_d;
  logic        op_full_q, op_full_d;
  logic [7:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;

  logic        fire;
  logic        a_xfer, b_xfer, op_xfer;
  logic [31:0] key_a, key_b;
  logic        is_eq, is_lt;
  logic        cmp_bit;

  // Map sign-magnitude to an unsigned key whose natural order matches the
  // float order. Both zeros collapse onto the +0 key so that -0 == +0.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[30:0] == 31'd0) begin
      order_key = 32'h8000_0000;
    end else if (x[31]) begin
      order_key = ~x;
    end else begin
      order_key = {1'b1, x[30:0]};
    end
  endfunction

  // The output register may be overwritten when it is empty or being drained.
  assign fire    = a_full_q & b_full_q & op_full_q & (~result_valid_q | result_ready);
  assign a_ready  = ~a_full_q  | fire;
  assign b_ready  = ~b_full_q  | fire;
  assign op_ready = ~op_full_q | fire;
  assign a_xfer   = a_valid  & a_ready;
  assign b_xfer   = b_valid  & b_ready;
  assign op_xfer  = op_valid & op_ready;

  assign key_a = order_key(a_q);
  assign key_b = order_key(b_q);
  assign is_eq = (key_a == key_b);
  assign is_lt = (key_a <  key_b);

  // Evaluate the held operation; reserved op codes yield false.
  always_comb begin
    cmp_bit = 1'b0;
    case (op_q)
      OP_EQ:   cmp_bit = is_eq;
      OP_NE:   cmp_bit = ~is_eq;
      OP_LT:   cmp_bit = is_lt;
      OP_LE:   cmp_bit = is_lt | is_eq;
      OP_GT:   cmp_bit = ~(is_lt | is_eq);
      OP_GE:   cmp_bit = ~is_lt;
      default: cmp_bit = 1'b0;
    endcase
`ifdef FCMP_NAN_CHECK_EN
    // NaNs are unordered: only NE holds, reserved codes stay false.
    if (((a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0)) ||
        ((b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0))) begin
      cmp_bit = (op_q == OP_NE);
    end
`else
    // NaNs are ordered by their key like any other value.
`endif
  end

  // Next-state for holding registers, full flags and the result register.
  always_comb begin
    a_d            = a_xfer  ? a  : a_q;
    b_d            = b_xfer  ? b  : b_q;
    op_d           = op_xfer ? op : op_q;
    a_full_d       = a_xfer  ? 1'b1 : (fire ? 1'b0 : a_full_q);
    b_full_d       = b_xfer  ? 1'b1 : (fire ? 1'b0 : b_full_q);
    op_full_d      = op_xfer ? 1'b1 : (fire ? 1'b0 : op_full_q);
    result_d       = result_q;
    result_valid_d = result_valid_q;
    if (fire) begin
      result_d       = {7'd0, cmp_bit};
      result_valid_d = 1'b1;
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any held operands and pending result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      op_q           <= 3'd0;
      a_full_q       <= 1'b0;
      b_full_q       <= 1'b0;
      op_full_q      <= 1'b0;
      result_q       <= 8'd0;
      result_valid_q <= 1'b0;
    end else begin
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      a_full_q       <= a_full_d;
      b_full_q       <= b_full_d;
      op_full_q      <= op_full_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fcmp_unit.sv
// ============================================================================
// Module      : tb_fcmp_unit
// Description : Directed self-checking bench for fcmp_unit with hand-computed
//               expected values. Honours FCMP_NAN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcmp_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] a, b;
  logic        a_valid, b_valid, op_valid;
  logic        a_ready, b_ready, op_ready;
  logic [2:0]  op;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_TWO  = 32'h4000_0000;
  localparam logic [31:0] F_MONE = 32'hBF80_0000;
  localparam logic [31:0] F_MTWO = 32'hC000_0000;
  localparam logic [31:0] F_PZ   = 32'h0000_0000;
  localparam logic [31:0] F_NZ   = 32'h8000_0000;
  localparam logic [31:0] F_INF  = 32'h7F80_0000;
  localparam logic [31:0] F_QNAN = 32'h7FC0_0000;

  fcmp_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .a            (a),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .b            (b),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .op           (op),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    op_valid = 1'b0;
  endtask

  // Offer all three channels in one cycle, then check the 2-edge latency,
  // the result value and the single-cycle result_valid pulse.
  task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [2:0] vop, input logic exp);
    a = va; b = vb; op = vop;
    a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
    tick();
    idle_inputs();
    chk({tag, ".lat1"}, {31'd0, result_valid}, 32'd0);
    tick();
    chk({tag, ".vld"}, {31'd0, result_valid}, 32'd1);
    chk({tag, ".res"}, {24'd0, result}, {31'd0, exp});
    tick();
    chk({tag, ".drop"}, {31'd0, result_valid}, 32'd0);
  endtask

  logic [31:0] tp_a [4];
  logic [31:0] tp_b [4];
  logic [2:0]  tp_op[4];
  logic        tp_exp[4];

  initial begin
    rstn = 1'b0;
    a = 32'd0; b = 32'd0; op = 3'd0;
    idle_inputs();
    result_ready = 1'b1;

    // Reset state
    tick();
    chk("rst.valid", {31'd0, result_valid}, 32'd0);
    chk("rst.result", {24'd0, result}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rst.a_ready", {31'd0, a_ready}, 32'd1);
    chk("rst.b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst.op_ready", {31'd0, op_ready}, 32'd1);

    // Basic comparisons
    do_op("lt_1_2",    F_ONE,  F_TWO,  3'd2, 1'b1);
    do_op("eq_z_nz",   F_PZ,   F_NZ,   3'd0, 1'b1);
    do_op("lt_z_nz",   F_PZ,   F_NZ,   3'd2, 1'b0);
    do_op("le_nz_z",   F_NZ,   F_PZ,   3'd3, 1'b1);
    do_op("ne_z_nz",   F_PZ,   F_NZ,   3'd1, 1'b0);
    do_op("lt_m2_m1",  F_MTWO, F_MONE, 3'd2, 1'b1);
    do_op("gt_m2_m1",  F_MTWO, F_MONE, 3'd4, 1'b0);
    do_op("lt_m1_1",   F_MONE, F_ONE,  3'd2, 1'b1);
    do_op("ge_1_1",    F_ONE,  F_ONE,  3'd5, 1'b1);
    do_op("gt_1_1",    F_ONE,  F_ONE,  3'd4, 1'b0);
    do_op("ne_1_2",    F_ONE,  F_TWO,  3'd1, 1'b1);
    do_op("gt_inf_1",  F_INF,  F_ONE,  3'd4, 1'b1);
    do_op("res_op6",   F_ONE,  F_ONE,  3'd6, 1'b0);
    do_op("res_op7",   F_ONE,  F_TWO,  3'd7, 1'b0);
`ifdef FCMP_NAN_CHECK_EN
    do_op("nan_eq",    F_QNAN, F_ONE,  3'd0, 1'b0);
    do_op("nan_ne",    F_QNAN, F_ONE,  3'd1, 1'b1);
    do_op("nan_gt",    F_QNAN, F_ONE,  3'd4, 1'b0);
`else
    do_op("nan_gt",    F_QNAN, F_ONE,  3'd4, 1'b1);
    do_op("nan_eq",    F_QNAN, F_ONE,  3'd0, 1'b0);
`endif

    // Staggered arrival: a at cycle 0, op at cycle 3, b at cycle 5
    a = F_ONE; a_valid = 1'b1;
    chk("stag.a_ready0", {31'd0, a_ready}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) a_valid = 1'b0;
      if (c <= 5) chk($sformatf("stag.a_ready%0d", c), {31'd0, a_ready}, 32'd0);
      if (c == 3) begin op = 3'd4; op_valid = 1'b1; end
      if (c == 4) op_valid = 1'b0;
      if (c == 5) begin b = F_MTWO; b_valid = 1'b1; end
      if (c == 6) begin
        b_valid = 1'b0;
        chk("stag.vld6", {31'd0, result_valid}, 32'd0);
      end
      if (c == 7) begin
        chk("stag.vld7", {31'd0, result_valid}, 32'd1);
        chk("stag.res7", {24'd0, result}, 32'd1);
      end
    end
    tick();
    chk("stag.drop", {31'd0, result_valid}, 32'd0);

    // Backpressure: two sets back-to-back with result_ready low
    result_ready = 1'b0;
    a = F_ONE; b = F_TWO; op = 3'd2;
    a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
    tick();
    chk("bp.accept2", {31'd0, a_ready & b_ready & op_ready}, 32'd1);
    op = 3'd4;
    tick();
    idle_inputs();
    for (int c = 2; c <= 3; c++) begin
      chk($sformatf("bp.hold_vld%0d", c), {31'd0, result_valid}, 32'd1);
      chk($sformatf("bp.hold_res%0d", c), {24'd0, result}, 32'd1);
      chk($sformatf("bp.rdy_low%0d", c), {29'd0, a_ready, b_ready, op_ready}, 32'd0);
      tick();
    end
    result_ready = 1'b1;
    #1;
    chk("bp.first_vld", {31'd0, result_valid}, 32'd1);
    chk("bp.first_res", {24'd0, result}, 32'd1);
    chk("bp.rdy_fire", {31'd0, a_ready}, 32'd1);
    tick();
    chk("bp.second_vld", {31'd0, result_valid}, 32'd1);
    chk("bp.second_res", {24'd0, result}, 32'd0);
    tick();
    chk("bp.drain", {31'd0, result_valid}, 32'd0);

    // Throughput: one new set per cycle, one result per cycle
    tp_a[0] = F_ONE; tp_b[0] = F_TWO; tp_op[0] = 3'd2; tp_exp[0] = 1'b1;
    tp_a[1] = F_ONE; tp_b[1] = F_TWO; tp_op[1] = 3'd4; tp_exp[1] = 1'b0;
    tp_a[2] = F_TWO; tp_b[2] = F_TWO; tp_op[2] = 3'd0; tp_exp[2] = 1'b1;
    tp_a[3] = F_TWO; tp_b[3] = F_ONE; tp_op[3] = 3'd3; tp_exp[3] = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c >= 2) begin
        chk($sformatf("tp.vld%0d", c), {31'd0, result_valid}, 32'd1);
        chk($sformatf("tp.res%0d", c), {24'd0, result}, {31'd0, tp_exp[c-2]});
      end
      if (c >= 1 && c <= 3) chk($sformatf("tp.rdy%0d", c), {31'd0, a_ready & b_ready & op_ready}, 32'd1);
      if (c < 4) begin
        a = tp_a[c]; b = tp_b[c]; op = tp_op[c];
        a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
      end else begin
        idle_inputs();
      end
      tick();
    end
    chk("tp.drain", {31'd0, result_valid}, 32'd0);

    // Reset mid-operation discards the captured operand
    a = F_ONE; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("mr.a_held", {31'd0, a_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("mr.rst_vld", {31'd0, result_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("mr.a_ready", {31'd0, a_ready}, 32'd1);
    b = F_TWO; op = 3'd2; b_valid = 1'b1; op_valid = 1'b1;
    tick();
    idle_inputs();
    chk("mr.a_ready2", {31'd0, a_ready}, 32'd1);
    chk("mr.b_held", {31'd0, b_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mr.no_vld%0d", c), {31'd0, result_valid}, 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
